// File: rtl/regfile_sb.sv
// ============================================================================
// Module   : regfile_sb
// Purpose  : Integer register file (x0 hard-wired to zero) with a per-register
//            pending scoreboard, flush, and a registered pending count.
// Options  : REGFILE_BYPASS_EN - same-cycle write-to-read forwarding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_w,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] rd_in,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rs1_out,
  output logic [XLEN-1:0] rs2_out,
  input  logic            iss_v,
  input  logic [AW-1:0]   iss_rd,
  input  logic            flush,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            iss_busy,
  output logic [AW:0]     pend_cnt
);

  localparam int unsigned c_NREG_U = NREG;

  // An index is live only if nonzero and inside the implemented register range;
  // everything else aliases x0.
  function automatic logic idx_ok(input logic [AW-1:0] a);
    return (a != '0) && (32'(a) < c_NREG_U);
  endfunction

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_pend;
  logic [AW:0]     r_cnt;

  logic            w_rd_ok;
  logic            w_iss_ok;
  logic            w_rs1_ok;
  logic            w_rs2_ok;
  logic            w_issrd_ok;
  logic [NREG-1:0] w_pend_nxt;
  logic [AW:0]     w_cnt_nxt;

  assign w_rd_ok    = rd_w  && idx_ok(rd);
  assign w_iss_ok   = iss_v && idx_ok(iss_rd);
  assign w_rs1_ok   = idx_ok(rs1);
  assign w_rs2_ok   = idx_ok(rs2);
  assign w_issrd_ok = idx_ok(iss_rd);

  // Write-back clears first, then issue sets, so a same-cycle issue wins;
  // flush overrides both.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_rd_ok) begin
      w_pend_nxt[rd] = 1'b0;
    end
    if (w_iss_ok) begin
      w_pend_nxt[iss_rd] = 1'b1;
    end
    if (flush) begin
      w_pend_nxt = '0;
    end
    w_pend_nxt[0] = 1'b0;
  end

  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 1; i < NREG; i++) begin
      w_cnt_nxt = w_cnt_nxt + (AW+1)'(w_pend_nxt[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_rd_ok) begin
      r_regs[rd] <= rd_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign pend_cnt = r_cnt;
  assign iss_busy = w_issrd_ok && r_pend[iss_rd];

`ifdef REGFILE_BYPASS_EN
  // Forwarding is suppressed during reset so outputs fall to zero at once.
  logic w_fwd1;
  logic w_fwd2;

  assign w_fwd1 = !rst && w_rd_ok && (rd == rs1);
  assign w_fwd2 = !rst && w_rd_ok && (rd == rs2);

  assign rs1_out  = !w_rs1_ok ? '0 : (w_fwd1 ? rd_in : r_regs[rs1]);
  assign rs2_out  = !w_rs2_ok ? '0 : (w_fwd2 ? rd_in : r_regs[rs2]);
  assign rs1_busy = w_rs1_ok && r_pend[rs1] && !w_fwd1;
  assign rs2_busy = w_rs2_ok && r_pend[rs2] && !w_fwd2;
`else
  assign rs1_out  = w_rs1_ok ? r_regs[rs1] : '0;
  assign rs2_out  = w_rs2_ok ? r_regs[rs2] : '0;
  assign rs1_busy = w_rs1_ok && r_pend[rs1];
  assign rs2_busy = w_rs2_ok && r_pend[rs2];
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// ============================================================================
// Module   : tb_regfile_sb
// Purpose  : Directed self-checking bench for regfile_sb (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_w;
  logic [4:0]  rd;
  logic [31:0] rd_in;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] rs1_out;
  logic [31:0] rs2_out;
  logic        iss_v;
  logic [4:0]  iss_rd;
  logic        flush;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        iss_busy;
  logic [5:0]  pend_cnt;

  int total = 0;
  int bad   = 0;

  regfile_sb #(.XLEN(32), .NREG(32), .AW(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_w     (rd_w),
    .rd       (rd),
    .rd_in    (rd_in),
    .rs1      (rs1),
    .rs2      (rs2),
    .rs1_out  (rs1_out),
    .rs2_out  (rs2_out),
    .iss_v    (iss_v),
    .iss_rd   (iss_rd),
    .flush    (flush),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .iss_busy (iss_busy),
    .pend_cnt (pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_w = 0; rd = 0; rd_in = 0; iss_v = 0; iss_rd = 0; flush = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle(); rs1 = 5; rs2 = 7;
    tick(); tick();
    total++; if (rs1_out !== 32'h0) begin bad++; $display("FAIL reset_rs1_out got=%h exp=0", rs1_out); end
    total++; if (pend_cnt !== 6'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", pend_cnt); end
    total++; if ({rs1_busy, rs2_busy, iss_busy} !== 3'b000) begin bad++; $display("FAIL reset_busy got=%b exp=000", {rs1_busy, rs2_busy, iss_busy}); end
    #2 rst = 0;
    tick();
  endtask

  task automatic test_write_read();
    rd_w = 1; rd = 5; rd_in = 32'hDEADBEEF;
    tick();
    idle(); rs1 = 5; rs2 = 0; #1;
    total++; if (rs1_out !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rd_x5 got=%h exp=deadbeef", rs1_out); end
    total++; if (rs2_out !== 32'h0) begin bad++; $display("FAIL wr_rd_x0 got=%h exp=0", rs2_out); end
  endtask

  task automatic test_x0();
    rd_w = 1; rd = 0; rd_in = 32'hFFFFFFFF; iss_v = 1; iss_rd = 0;
    tick();
    idle(); rs1 = 0; #1;
    total++; if (rs1_out !== 32'h0) begin bad++; $display("FAIL x0_read got=%h exp=0", rs1_out); end
    total++; if (pend_cnt !== 6'd0) begin bad++; $display("FAIL x0_cnt got=%0d exp=0", pend_cnt); end
    total++; if (iss_busy !== 1'b0) begin bad++; $display("FAIL x0_iss_busy got=%b exp=0", iss_busy); end
  endtask

  task automatic test_pending();
    iss_v = 1; iss_rd = 3; tick();
    iss_rd = 7; tick();
    idle(); rs1 = 3; rs2 = 7; iss_rd = 7; #1;
    total++; if (pend_cnt !== 6'd2) begin bad++; $display("FAIL pend_cnt2 got=%0d exp=2", pend_cnt); end
    total++; if ({rs1_busy, rs2_busy, iss_busy} !== 3'b111) begin bad++; $display("FAIL pend_busy got=%b exp=111", {rs1_busy, rs2_busy, iss_busy}); end
    rd_w = 1; rd = 3; rd_in = 32'h33; #1;
`ifdef REGFILE_BYPASS_EN
    total++; if (rs1_busy !== 1'b0) begin bad++; $display("FAIL pend_prewr_busy got=%b exp=0", rs1_busy); end
`else
    total++; if (rs1_busy !== 1'b1) begin bad++; $display("FAIL pend_prewr_busy got=%b exp=1", rs1_busy); end
`endif
    tick();
    idle(); rs1 = 3; rs2 = 7; #1;
    total++; if (pend_cnt !== 6'd1) begin bad++; $display("FAIL pend_cnt1 got=%0d exp=1", pend_cnt); end
    total++; if ({rs1_busy, rs2_busy} !== 2'b01) begin bad++; $display("FAIL pend_after_wr got=%b exp=01", {rs1_busy, rs2_busy}); end
    total++; if (rs1_out !== 32'h33) begin bad++; $display("FAIL pend_x3_data got=%h exp=33", rs1_out); end
  endtask

  task automatic test_issue_wins();
    iss_v = 1; iss_rd = 9; rd_w = 1; rd = 9; rd_in = 32'h12; #1;
    total++; if (iss_busy !== 1'b0) begin bad++; $display("FAIL iw_pre_iss_busy got=%b exp=0", iss_busy); end
    tick();
    idle(); rs1 = 9; #1;
    total++; if (rs1_busy !== 1'b1) begin bad++; $display("FAIL iw_busy got=%b exp=1", rs1_busy); end
    total++; if (rs1_out !== 32'h12) begin bad++; $display("FAIL iw_data got=%h exp=12", rs1_out); end
    total++; if (pend_cnt !== 6'd2) begin bad++; $display("FAIL iw_cnt got=%0d exp=2", pend_cnt); end
  endtask

  task automatic test_flush();
    iss_v = 1; iss_rd = 11; tick();
    iss_rd = 12; tick();
    idle(); #1;
    total++; if (pend_cnt !== 6'd4) begin bad++; $display("FAIL fl_cnt4 got=%0d exp=4", pend_cnt); end
    flush = 1; iss_v = 1; iss_rd = 10; rd_w = 1; rd = 13; rd_in = 32'hAB;
    tick();
    idle(); rs1 = 10; rs2 = 13; iss_rd = 7; #1;
    total++; if (pend_cnt !== 6'd0) begin bad++; $display("FAIL fl_cnt0 got=%0d exp=0", pend_cnt); end
    total++; if ({rs1_busy, iss_busy} !== 2'b00) begin bad++; $display("FAIL fl_busy got=%b exp=00", {rs1_busy, iss_busy}); end
    total++; if (rs2_out !== 32'hAB) begin bad++; $display("FAIL fl_wr_data got=%h exp=ab", rs2_out); end
  endtask

  task automatic test_bypass();
    rd_w = 1; rd = 4; rd_in = 32'h11; tick();
    rd_in = 32'h55; rs1 = 4; rs2 = 5; #1;
`ifdef REGFILE_BYPASS_EN
    total++; if (rs1_out !== 32'h55) begin bad++; $display("FAIL byp_same got=%h exp=55", rs1_out); end
`else
    total++; if (rs1_out !== 32'h11) begin bad++; $display("FAIL byp_same got=%h exp=11", rs1_out); end
`endif
    total++; if (rs2_out !== 32'hDEADBEEF) begin bad++; $display("FAIL byp_other got=%h exp=deadbeef", rs2_out); end
    tick();
    idle(); #1;
    total++; if (rs1_out !== 32'h55) begin bad++; $display("FAIL byp_next got=%h exp=55", rs1_out); end
  endtask

  task automatic test_back_to_back();
    for (int i = 20; i < 24; i++) begin
      rd_w = 1; rd = 5'(i); rd_in = 32'h100 + 32'(i); iss_v = 1; iss_rd = 5'(i + 1);
      tick();
    end
    idle(); #1;
    // x21..x23 were issued then written; x24 remains pending.
    total++; if (pend_cnt !== 6'd1) begin bad++; $display("FAIL b2b_cnt got=%0d exp=1", pend_cnt); end
    rs1 = 22; rs2 = 24; #1;
    total++; if (rs1_out !== 32'h116) begin bad++; $display("FAIL b2b_data got=%h exp=116", rs1_out); end
    total++; if ({rs1_busy, rs2_busy} !== 2'b01) begin bad++; $display("FAIL b2b_busy got=%b exp=01", {rs1_busy, rs2_busy}); end
  endtask

  task automatic test_async_reset();
    rs1 = 24; rs2 = 5; #3;
    rst = 1; #1;
    total++; if (rs2_out !== 32'h0) begin bad++; $display("FAIL arst_data got=%h exp=0", rs2_out); end
    total++; if ({rs1_busy, pend_cnt} !== 7'd0) begin bad++; $display("FAIL arst_state got=%b/%0d exp=0/0", rs1_busy, pend_cnt); end
    rd_w = 1; rd = 6; rd_in = 32'h66; iss_v = 1; iss_rd = 6;
    tick();
    idle(); #2 rst = 0;
    rs1 = 6; #1;
    total++; if ({rs1_out, rs1_busy, pend_cnt} !== 39'd0) begin bad++; $display("FAIL arst_ignore got=%h/%b/%0d exp=0/0/0", rs1_out, rs1_busy, pend_cnt); end
  endtask

  initial begin
    idle(); rst = 1; rs1 = 0; rs2 = 0;
    test_reset();
    test_write_read();
    test_x0();
    test_pending();
    test_issue_wins();
    test_flush();
    test_bypass();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have parameter NREG, default 32, architectural register count; legal values 16 (RV32E) or 32.
REQ-003 SHALL have parameter AW, default 5, register-index width; AW = log2(NREG) when NREG=32, AW=4 when NREG=16.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port rd_w  input  1  write-back enable.
REQ-007 SHALL have port rd  input  AW  write-back register index.
REQ-008 SHALL have port rd_in  input  XLEN  write-back data.
REQ-009 SHALL have port rs1, rs2  input  AW each  read indices.
REQ-010 SHALL have port rs1_out, rs2_out  output  XLEN each  read data.
REQ-011 SHALL have port iss_v  input  1  issue strobe; marks iss_rd pending.
REQ-012 SHALL have port iss_rd  input  AW  destination index of issuing instruction.
REQ-013 SHALL have port flush  input  1  clear all pending marks.
REQ-014 SHALL have port rs1_busy, rs2_busy, iss_busy  output  1 each  pending status of rs1, rs2, iss_rd.
REQ-015 SHALL have port pend_cnt  output  AW+1  number of registers currently pending.

Function
REQ-016 SHALL return 0 on rs1_out/rs2_out and 0 on rs1_busy/rs2_busy/iss_busy whenever the corresponding index is 0, regardless of writes or issues.
REQ-017 SHALL perform combinational reads: rs*_out = stored value of indexed register, zero read latency.
REQ-018 SHALL write rd_in to register rd at rising edge iff rd_w=1 and rd!=0; writes to index 0 discarded.
REQ-019 SHALL keep one pending bit per register 1..NREG-1; index 0 never pending.
REQ-020 SHALL set pending[iss_rd] at rising edge when iss_v=1 and iss_rd!=0.
REQ-021 SHALL clear pending[rd] at rising edge when rd_w=1 and rd!=0.
REQ-022 SHALL, when iss_v and rd_w target the same nonzero index in one cycle, leave that register pending (issue wins); data is still written.
REQ-023 SHALL, when flush=1, clear all pending bits at rising edge; flush overrides same-cycle iss_v; same-cycle rd_w data write still occurs.
REQ-024 SHALL drive busy outputs combinationally from current pending state (pre-edge), not from same-cycle iss_v.
REQ-025 SHALL keep pend_cnt equal to the population count of pending bits, registered, updated in same edge as the pending bits; range 0..NREG-1, never wraps.
REQ-026 SHALL treat rd, rs1, rs2, iss_rd with index >= NREG (only possible if AW oversized) as index 0.

Reset
REQ-027 SHALL, while rst=1, asynchronously clear all registers to 0, all pending bits to 0, pend_cnt to 0.
REQ-028 SHALL, with rst asserted mid-cycle, make rs*_out=0, all busy=0, pend_cnt=0 immediately, without waiting for clk; writes and issues ignored while rst=1.

Configuration
REQ-029 SHALL honour macro REGFILE_BYPASS_EN: when defined, a read whose nonzero index equals rd with rd_w=1 returns rd_in in the same cycle and its busy output reads 0 (unless REQ-022 issue also targets it, busy still reads current pending=0-after-write semantics: busy forced 0); when undefined, reads return stored value and pending state only, write visible next cycle.

Verification
REQ-030 SHALL cover: reset, then write x5=0xDEADBEEF, read rs1=5 next cycle -> rs1_out=0xDEADBEEF; rs2=0 -> rs2_out=0.
REQ-031 SHALL cover: rd_w=1, rd=0, rd_in=0xFFFFFFFF; then rs1=0 -> rs1_out=0, pend_cnt=0.
REQ-032 SHALL cover: iss_v x3, x7 on consecutive cycles -> pend_cnt=2, rs1=3 busy=1; write x3 -> pend_cnt=1, rs1_busy=0.
REQ-033 SHALL cover: same cycle iss_v x9 and rd_w x9=0x12 -> next cycle x9 busy=1, data 0x12, pend_cnt incremented by 1.
REQ-034 SHALL cover: 4 registers pending, flush with iss_v x10 same cycle -> pend_cnt=0, x10 not busy.
REQ-035 SHALL cover: with REGFILE_BYPASS_EN, rd_w x4=0x55 and rs1=4 same cycle -> rs1_out=0x55 that cycle; without macro -> old value that cycle, 0x55 next.
